id_stage_fwd_hs: RTL and testbench

- Parametrised decode-stage front end: instruction/PC pipeline register with a valid/allowin handshake, plus generalised operand bypass from NFWD producer stages.
- Adds a HI/LO scoreboard so MFHI/MFLO wait for in-flight MULT/DIV, and a flush input for branch and exception redirect.
- Sits between fetch and execute. Feeds the register-file read ports and the execute operand latches.

---
 rtl/cpu_defs_pkg.sv | 45 ++++
 rtl/fwd_select.sv | 34 +++
 rtl/id_stage_fwd_hs.sv | 139 +++++++++++++
 tb/tb_id_stage_fwd_hs.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS opcode/funct constants and decode helpers for the decode stage.
package cpu_defs_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SWL     = 6'h2a;
   localparam logic [5:0] OP_SW      = 6'h2b;
   localparam logic [5:0] OP_SWR     = 6'h2e;

   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1a;
   localparam logic [5:0] FN_DIVU    = 6'h1b;

   localparam logic [31:0] DEF_RESET_PC = 32'hbfc00000;

   function automatic logic is_store(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_store = 1'b1;
         default:                             is_store = 1'b0;
      endcase
   endfunction

   function automatic logic is_hilo_writer(input logic [5:0] op, input logic [5:0] fn);
      if (op == OP_SPECIAL) begin
         case (fn)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: is_hilo_writer = 1'b1;
            default:                                              is_hilo_writer = 1'b0;
         endcase
      end else begin
         is_hilo_writer = 1'b0;
      end
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority bypass mux: the lowest-index (youngest) producer writing raddr wins.
module fwd_select #(
   parameter int XLEN = 32,
   parameter int RA_W = 5,
   parameter int NFWD = 3
)(
   input  logic [RA_W-1:0]      i_raddr,
   input  logic [NFWD-1:0]      i_valid,
   input  logic [NFWD*RA_W-1:0] i_dest,
   input  logic [NFWD-1:0]      i_ready,
   input  logic [NFWD*XLEN-1:0] i_value,
   output logic                 o_hit,
   output logic                 o_ready,
   output logic [XLEN-1:0]      o_value
);

   // First matching producer only; register 0 is never a bypass target.
   always_comb begin
      o_hit   = 1'b0;
      o_ready = 1'b0;
      o_value = {XLEN{1'b0}};
      for (int i = 0; i < NFWD; i++) begin
         if (!o_hit && i_valid[i] && (i_dest[i*RA_W +: RA_W] != {RA_W{1'b0}})
             && (i_dest[i*RA_W +: RA_W] == i_raddr)) begin
            o_hit   = 1'b1;
            o_ready = i_ready[i];
            o_value = i_value[i*XLEN +: XLEN];
         end else begin
            o_hit   = o_hit;
         end
      end
   end

endmodule

// File: rtl/id_stage_fwd_hs.sv
// Decode-stage front end: instruction/PC register with valid/allowin handshake,
// NFWD-source operand bypass and a HI/LO in-flight writer scoreboard.
module id_stage_fwd_hs
   import cpu_defs_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              RA_W     = 5,
   parameter int              NFWD     = 3,
   parameter int              MAX_HILO = 3,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
)(
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         fs_valid,
   input  logic [31:0]                  fs_inst,
   input  logic [XLEN-1:0]              fs_pc,
   output logic                         ds_allowin,
   input  logic                         es_allowin,
   input  logic                         flush,
   output logic                         ds_valid,
   output logic                         ds_to_es_valid,
   output logic [31:0]                  ds_inst,
   output logic [XLEN-1:0]              ds_pc,
   output logic [RA_W-1:0]              rf_raddr1,
   output logic [RA_W-1:0]              rf_raddr2,
   input  logic [XLEN-1:0]              rf_rdata1,
   input  logic [XLEN-1:0]              rf_rdata2,
   input  logic [NFWD-1:0]              fwd_valid,
   input  logic [NFWD*RA_W-1:0]         fwd_dest,
   input  logic [NFWD-1:0]              fwd_ready,
   input  logic [NFWD*XLEN-1:0]         fwd_value,
   input  logic                         hilo_done,
   output logic [XLEN-1:0]              src1_value,
   output logic [XLEN-1:0]              src2_value,
   output logic                         stall,
   output logic [$clog2(MAX_HILO+1)-1:0] hilo_pending
);

   localparam int              HP_W   = $clog2(MAX_HILO+1);
   localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HILO);
   localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

   logic            r_valid;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_pc;
   logic [HP_W-1:0] r_hilo_cnt;

   logic [5:0]      w_op, w_fn;
   logic            w_use_rs, w_use_rt, w_hilo_wr, w_hilo_rd;
   logic            w_hit1, w_rdy1, w_hit2, w_rdy2;
   logic [XLEN-1:0] w_val1, w_val2;
   logic            w_rs_haz, w_rt_haz, w_hilo_haz;
   logic            w_hilo_inc, w_hilo_dec;

   assign w_op = r_inst[31:26];
   assign w_fn = r_inst[5:0];

   // Operand usage and HI/LO role of the held instruction.
   always_comb begin
      w_use_rs  = !((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_LUI));
      w_use_rt  = (w_op == OP_SPECIAL) || (w_op == OP_BEQ) || (w_op == OP_BNE) || is_store(w_op);
      w_hilo_wr = is_hilo_writer(w_op, w_fn);
      w_hilo_rd = (w_op == OP_SPECIAL) && ((w_fn == FN_MFHI) || (w_fn == FN_MFLO));
   end

   assign rf_raddr1 = RA_W'(r_inst[25:21]);
   assign rf_raddr2 = RA_W'(r_inst[20:16]);

   fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .NFWD(NFWD)) u_fwd_rs (
      .i_raddr (rf_raddr1), .i_valid (fwd_valid), .i_dest (fwd_dest),
      .i_ready (fwd_ready), .i_value (fwd_value),
      .o_hit   (w_hit1),    .o_ready (w_rdy1),    .o_value (w_val1)
   );

   fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .NFWD(NFWD)) u_fwd_rt (
      .i_raddr (rf_raddr2), .i_valid (fwd_valid), .i_dest (fwd_dest),
      .i_ready (fwd_ready), .i_value (fwd_value),
      .o_hit   (w_hit2),    .o_ready (w_rdy2),    .o_value (w_val2)
   );

   // Operand mux: a matched-but-unready producer becomes a hazard instead.
   always_comb begin
      w_rs_haz   = 1'b0;
      w_rt_haz   = 1'b0;
      src1_value = rf_rdata1;
      src2_value = rf_rdata2;
      if (w_use_rs && w_hit1) begin
         if (w_rdy1) src1_value = w_val1;
         else        w_rs_haz   = 1'b1;
      end else begin
         src1_value = rf_rdata1;
      end
      if (w_use_rt && w_hit2) begin
         if (w_rdy2) src2_value = w_val2;
         else        w_rt_haz   = 1'b1;
      end else begin
         src2_value = rf_rdata2;
      end
   end

   assign w_hilo_haz     = (w_hilo_rd && (r_hilo_cnt != {HP_W{1'b0}}))
                         || (w_hilo_wr && (r_hilo_cnt == HP_MAX));
   assign stall          = r_valid && (w_rs_haz || w_rt_haz || w_hilo_haz);
   assign ds_allowin     = !r_valid || (!stall && es_allowin);
   assign ds_to_es_valid = r_valid && !stall;
   assign w_hilo_inc     = ds_to_es_valid && es_allowin && w_hilo_wr;
   assign w_hilo_dec     = hilo_done && (r_hilo_cnt != {HP_W{1'b0}});

   // Stage register; flush wins over a same-cycle load.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_inst  <= 32'h0000_0000;
         r_pc    <= RESET_PC;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (ds_allowin) begin
         r_valid <= fs_valid;
         if (fs_valid) begin
            r_inst <= fs_inst;
            r_pc   <= fs_pc;
         end
      end
   end

   // In-flight HI/LO writer count; simultaneous issue and retire cancel.
   always_ff @(posedge clk) begin
      if (!resetn)                       r_hilo_cnt <= {HP_W{1'b0}};
      else if (w_hilo_inc && !w_hilo_dec) r_hilo_cnt <= r_hilo_cnt + HP_ONE;
      else if (!w_hilo_inc && w_hilo_dec) r_hilo_cnt <= r_hilo_cnt - HP_ONE;
      else                               r_hilo_cnt <= r_hilo_cnt;
   end

   assign ds_valid     = r_valid;
   assign ds_inst      = r_inst;
   assign ds_pc        = r_pc;
   assign hilo_pending = r_hilo_cnt;

endmodule

// File: tb/tb_id_stage_fwd_hs.sv
// Randomized bench for id_stage_fwd_hs against a cycle-level reference model.
module tb_id_stage_fwd_hs;

   logic        clk = 1'b0;
   logic        resetn, fs_valid, es_allowin, flush, hilo_done;
   logic [31:0] fs_inst, fs_pc, rf_rdata1, rf_rdata2;
   logic        ds_allowin, ds_valid, ds_to_es_valid, stall;
   logic [31:0] ds_inst, ds_pc, src1_value, src2_value;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [1:0]  hilo_pending;
   logic [2:0]  fwd_valid, fwd_ready;
   logic [4:0]  dst [3];
   logic [31:0] val [3];
   logic [14:0] fwd_dest;
   logic [95:0] fwd_value;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state
   bit          m_valid;
   logic [31:0] m_inst, m_pc;
   int          m_pend;
   bit          m_just_reset;

   assign fwd_dest  = {dst[2], dst[1], dst[0]};
   assign fwd_value = {val[2], val[1], val[0]};

   always #5 clk = ~clk;

   id_stage_fwd_hs dut (
      .clk(clk), .resetn(resetn), .fs_valid(fs_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
      .ds_allowin(ds_allowin), .es_allowin(es_allowin), .flush(flush), .ds_valid(ds_valid),
      .ds_to_es_valid(ds_to_es_valid), .ds_inst(ds_inst), .ds_pc(ds_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_value(fwd_value),
      .hilo_done(hilo_done), .src1_value(src1_value), .src2_value(src2_value),
      .stall(stall), .hilo_pending(hilo_pending)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic bit uses_rs(input logic [31:0] in);
      int op = int'(in[31:26]);
      return !(op == 2 || op == 3 || op == 15);
   endfunction

   function automatic bit uses_rt(input logic [31:0] in);
      int op = int'(in[31:26]);
      return op == 0 || op == 4 || op == 5 || op == 'h28 || op == 'h29 || op == 'h2a
             || op == 'h2b || op == 'h2e;
   endfunction

   function automatic bit hl_writer(input logic [31:0] in);
      int fn = int'(in[5:0]);
      return in[31:26] == 6'h00 && (fn == 'h18 || fn == 'h19 || fn == 'h1a || fn == 'h1b
                                    || fn == 'h11 || fn == 'h13);
   endfunction

   function automatic bit hl_reader(input logic [31:0] in);
      return in[31:26] == 6'h00 && (in[5:0] == 6'h10 || in[5:0] == 6'h12);
   endfunction

   // Index of the youngest producer of register r, or -1.
   function automatic int producer_of(input logic [4:0] r);
      if (r == 5'd0) return -1;
      for (int i = 0; i < 3; i++)
         if (fwd_valid[i] && dst[i] == r) return i;
      return -1;
   endfunction

   // Resolve one operand: returns 1 on a hazard, value otherwise.
   function automatic bit operand(input bit used, input logic [4:0] r, input logic [31:0] rf,
                                  output logic [31:0] v);
      int k = used ? producer_of(r) : -1;
      v = rf;
      if (k < 0) return 1'b0;
      if (!fwd_ready[k]) return 1'b1;
      v = val[k];
      return 1'b0;
   endfunction

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic step();
      logic [31:0] e1, e2;
      bit h1, h2, hh, e_stall, e_allow, fire;
      int n_pend;
      #1;
      h1 = operand(uses_rs(m_inst), m_inst[25:21], rf_rdata1, e1);
      h2 = operand(uses_rt(m_inst), m_inst[20:16], rf_rdata2, e2);
      hh = (hl_reader(m_inst) && m_pend != 0) || (hl_writer(m_inst) && m_pend == 3);
      e_stall = m_valid && (h1 || h2 || hh);
      e_allow = !m_valid || (!e_stall && es_allowin);
      check("stall", 32'(stall), 32'(e_stall));
      check("allowin", 32'(ds_allowin), 32'(e_allow));
      check("to_es", 32'(ds_to_es_valid), 32'(m_valid && !e_stall));
      if (m_valid) begin
         check("src1", src1_value, e1);
         check("src2", src2_value, e2);
         check("raddr1", 32'(rf_raddr1), 32'(m_inst[25:21]));
         check("raddr2", 32'(rf_raddr2), 32'(m_inst[20:16]));
      end
      fire   = m_valid && !e_stall && es_allowin;
      n_pend = m_pend + ((fire && hl_writer(m_inst)) ? 1 : 0)
                      - ((hilo_done && m_pend > 0) ? 1 : 0);
      @(posedge clk);
      #1;
      m_just_reset = 1'b0;
      if (!resetn) begin
         m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'hbfc00000; m_pend = 0; m_just_reset = 1'b1;
      end else begin
         m_pend = n_pend;
         if (flush) m_valid = 1'b0;
         else if (e_allow) begin
            m_valid = fs_valid;
            if (fs_valid) begin m_inst = fs_inst; m_pc = fs_pc; end
         end
      end
      check("ds_valid", 32'(ds_valid), 32'(m_valid));
      check("pending", 32'(hilo_pending), 32'(m_pend));
      if (m_valid || m_just_reset) begin
         check("ds_inst", ds_inst, m_inst);
         check("ds_pc", ds_pc, m_pc);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      resetn = 1'b1; fs_valid = 1'b0; fs_inst = 32'h0; fs_pc = 32'h0; es_allowin = 1'b1;
      flush = 1'b0; hilo_done = 1'b0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
      fwd_valid = 3'b000; fwd_ready = 3'b111;
      for (int i = 0; i < 3; i++) begin dst[i] = 5'd0; val[i] = 32'h0; end
   endtask

   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      fs_valid = 1'b1; fs_inst = inst; fs_pc = pc;
   endtask

   function automatic logic [31:0] rand_inst();
      int rs = int'($urandom_range(0, 7));
      int rt = int'($urandom_range(0, 7));
      int rd = int'($urandom_range(0, 7));
      case ($urandom_range(0, 10))
         0:       return rtype(rs, rt, rd, 'h21);
         1:       return rtype(rs, rt, 0, 'h18);
         2:       return rtype(rs, rt, 0, 'h1b);
         3:       return rtype(0, 0, rd, 'h10);
         4:       return rtype(0, 0, rd, 'h12);
         5:       return rtype(rs, 0, 0, 'h13);
         6:       return itype('h04, rs, rt, int'($urandom_range(0, 255)));
         7:       return itype('h2b, rs, rt, 4);
         8:       return itype('h0f, rs, rt, 'h1234);
         9:       return {6'h02, 26'($urandom)};
         default: return itype('h23, rs, rt, 8);
      endcase
   endfunction

   initial begin
      idle();
      resetn = 1'b0;
      m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0; m_pend = 0; m_just_reset = 1'b0;
      @(negedge clk);
      step(); step();
      check("rst_valid", 32'(ds_valid), 32'h0);
      check("rst_pc", ds_pc, 32'hbfc00000);
      check("rst_pend", 32'(hilo_pending), 32'h0);

      // ADDU $3,$1,$2 enters decode
      resetn = 1'b1; offer(rtype(1, 2, 3, 'h21), 32'h0000_1000); step();
      check("addu_pc", ds_pc, 32'h0000_1000);
      fs_valid = 1'b0; rf_rdata1 = 32'hcafe_0001; rf_rdata2 = 32'hcafe_0002; step();

      // youngest of two matching producers wins
      offer(rtype(5, 0, 6, 'h21), 32'h0000_1004); step();
      fs_valid = 1'b0; fwd_valid = 3'b011; dst[0] = 5'd5; dst[1] = 5'd5;
      val[0] = 32'h11; val[1] = 32'h22;
      #1 check("youngest", src1_value, 32'h11);
      step();

      // unready producer on rt stalls until it becomes ready
      offer(rtype(0, 7, 8, 'h21), 32'h0000_1008); fwd_valid = 3'b000; step();
      offer(rtype(1, 1, 1, 'h21), 32'h0000_100c);
      fwd_valid = 3'b001; dst[0] = 5'd7; fwd_ready = 3'b110; step();
      check("held_pc", ds_pc, 32'h0000_1008);
      fwd_ready = 3'b111; val[0] = 32'hdead;
      #1 check("rt_bypass", src2_value, 32'hdead);
      step();
      fwd_valid = 3'b000; fs_valid = 1'b0; step();

      // MULT then MFHI; MFHI waits for hilo_done
      offer(rtype(1, 2, 0, 'h18), 32'h2000); step();
      offer(rtype(0, 0, 4, 'h10), 32'h2004); step();
      fs_valid = 1'b0; step(); step();
      hilo_done = 1'b1; step(); hilo_done = 1'b0; step();

      // saturate the scoreboard, then retire while a fourth writer waits
      for (int i = 0; i < 4; i++) begin offer(rtype(1, 2, 0, 'h18), 32'h3000 + 32'(4*i)); step(); end
      fs_valid = 1'b0; step();
      check("sat_pend", 32'(hilo_pending), 32'd3);
      hilo_done = 1'b1; step(); hilo_done = 1'b0; step(); step();

      // flush while stalled, then reset while stalled
      offer(rtype(0, 0, 4, 'h12), 32'h4000); step();
      offer(rtype(1, 1, 1, 'h21), 32'h4004); flush = 1'b1; step();
      flush = 1'b0; fs_valid = 1'b0;
      offer(rtype(0, 0, 4, 'h12), 32'h4008); step(); fs_valid = 1'b0; step();
      resetn = 1'b0; step(); resetn = 1'b1;
      check("mid_rst_pc", ds_pc, 32'hbfc00000);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         resetn     = ($urandom_range(0, 299) != 0);
         fs_valid   = 1'($urandom_range(0, 3) != 0);
         fs_inst    = rand_inst();
         fs_pc      = $urandom & 32'hffff_fffc;
         es_allowin = 1'($urandom_range(0, 4) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         hilo_done  = ($urandom_range(0, 3) == 0);
         rf_rdata1  = $urandom;
         rf_rdata2  = $urandom;
         fwd_valid  = 3'($urandom);
         fwd_ready  = 3'($urandom) | 3'($urandom);
         for (int i = 0; i < 3; i++) begin
            dst[i] = 5'($urandom_range(0, 7));
            val[i] = $urandom;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
